// File: rtl/calc_sequencer_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
// Holds the FSM state enum, the operator codes and the default execution latencies.
package calc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GOT_A  = 3'd1,
    ST_GOT_OP = 3'd2,
    ST_GOT_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } calc_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned ADD_LAT_DEF = 1;
  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned DIV_LAT_DEF = 4;

  // Counter preload for an operator: EXEC lasts preload+1 cycles.
  function automatic logic [3:0] exec_load(input logic [1:0]   op,
                                           input int unsigned add_lat,
                                           input int unsigned mul_lat,
                                           input int unsigned div_lat);
    int unsigned lat;
    lat = add_lat;
    case (op)
      OP_MUL:  lat = mul_lat;
      OP_DIV:  lat = div_lat;
      default: lat = add_lat;
    endcase
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/calc_lat_counter.sv
// Loadable 4-bit down-counter that times the EXEC phase.
// Saturates at zero; clear and load take effect on the next rising edge.
module calc_lat_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects operand/operator/equals strobes, drives an
// external arithmetic mux for a per-operator latency and latches the returned result.
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int unsigned ADD_LAT = ADD_LAT_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        num_valid,
  input  logic [3:0]  num,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic        eq_valid,
  input  logic [7:0]  y,
  output logic [3:0]  opa,
  output logic [3:0]  opb,
  output logic [1:0]  ss,
  output logic        mux_en,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic        busy,
  output logic        err,
  output calc_state_e dbg_state
);

  calc_state_e state_q;
  logic [3:0]  opa_q;
  logic [3:0]  opb_q;
  logic [1:0]  ss_q;
  logic [7:0]  result_q;
  logic        result_valid_q;
  logic        busy_q;
  logic        mux_en_q;
  logic        err_q;

  logic        eq_ev;
  logic        op_ev;
  logic        num_ev;
  logic        div_zero;
  logic        cnt_load;
  logic [3:0]  cnt_load_val;
  logic        cnt_zero;

  // Only the highest-priority strobe of a cycle is an event; clr overrides all of them.
  assign eq_ev  = eq_valid;
  assign op_ev  = op_valid & ~eq_valid;
  assign num_ev = num_valid & ~op_valid & ~eq_valid;

  assign div_zero     = (ss_q == OP_DIV) && (opb_q == 4'd0);
  assign cnt_load     = (state_q == ST_GOT_B) && eq_ev && !clr && !div_zero;
  assign cnt_load_val = exec_load(ss_q, ADD_LAT, MUL_LAT, DIV_LAT);

  calc_lat_counter u_lat_counter (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (state_q == ST_EXEC),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      opa_q          <= 4'd0;
      opb_q          <= 4'd0;
      ss_q           <= OP_ADD;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      mux_en_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (clr) begin
        state_q  <= ST_IDLE;
        opa_q    <= 4'd0;
        opb_q    <= 4'd0;
        ss_q     <= OP_ADD;
        result_q <= 8'h00;
        busy_q   <= 1'b0;
        mux_en_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_EXEC: begin
            if (cnt_zero) begin
              result_q       <= y;
              result_valid_q <= 1'b1;
              busy_q         <= 1'b0;
              mux_en_q       <= 1'b0;
              state_q        <= ST_DONE;
            end
          end
          ST_GOT_B: begin
            if (eq_ev) begin
              if (div_zero) begin
                err_q   <= 1'b1;
                state_q <= ST_ERR;
              end else begin
                busy_q   <= 1'b1;
                mux_en_q <= 1'b1;
                state_q  <= ST_EXEC;
              end
            end else if (op_ev) begin
              ss_q <= op;
            end else if (num_ev) begin
              opb_q <= num;
            end
          end
          ST_GOT_A: begin
            if (op_ev) begin
              ss_q    <= op;
              state_q <= ST_GOT_OP;
            end else if (num_ev) begin
              opa_q <= num;
            end
          end
          ST_GOT_OP: begin
            if (op_ev) begin
              ss_q <= op;
            end else if (num_ev) begin
              opb_q   <= num;
              state_q <= ST_GOT_B;
            end
          end
          ST_DONE: begin
            // Chained calculation: the low nibble of the last result becomes operand A.
            if (op_ev) begin
              opa_q   <= result_q[3:0];
              ss_q    <= op;
              state_q <= ST_GOT_OP;
            end else if (num_ev) begin
              opa_q   <= num;
              state_q <= ST_GOT_A;
            end
          end
          default: begin
            if (num_ev) begin
              opa_q   <= num;
              err_q   <= 1'b0;
              state_q <= ST_GOT_A;
            end
          end
        endcase
      end
    end
  end

  assign opa          = opa_q;
  assign opb          = opb_q;
  assign ss           = ss_q;
  assign mux_en       = mux_en_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed key sequences plus random strobes
// compared against a keypad-level model that also plays the role of the arithmetic units.
module tb_calc_sequencer;
  import calc_sequencer_pkg::*;

  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        num_valid = 1'b0;
  logic [3:0]  num = 4'd0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        eq_valid = 1'b0;
  logic [7:0]  y = 8'h00;
  logic [3:0]  opa, opb;
  logic [1:0]  ss;
  logic        mux_en, result_valid, busy, err;
  logic [7:0]  result;
  calc_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef enum {M_IDLE, M_A, M_OP, M_B, M_EXEC, M_DONE, M_ERR} mphase_e;
  mphase_e    m_phase = M_IDLE;
  logic [3:0] m_opa = 4'd0, m_opb = 4'd0;
  logic [1:0] m_ss = 2'd0;
  logic [7:0] m_result = 8'h00;
  int         m_left = 0;
  bit         m_rv = 1'b0;

  calc_sequencer #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .num_valid(num_valid), .num(num),
    .op_valid(op_valid), .op(op), .eq_valid(eq_valid), .y(y),
    .opa(opa), .opb(opb), .ss(ss), .mux_en(mux_en), .result(result),
    .result_valid(result_valid), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] calc_y(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    int r;
    case (s)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a) * int'(b);
      default: r = (b == 4'd0) ? 0 : int'(a) / int'(b);
    endcase
    return r[7:0];
  endfunction

  function automatic int lat_of(input logic [1:0] s);
    if (s == 2'd2) return MUL_LAT;
    if (s == 2'd3) return DIV_LAT;
    return ADD_LAT;
  endfunction

  function automatic void model_reset();
    m_phase = M_IDLE; m_opa = 4'd0; m_opb = 4'd0; m_ss = 2'd0;
    m_result = 8'h00; m_left = 0; m_rv = 1'b0;
  endfunction

  function automatic void model_step(input bit c, input bit e, input bit o, input bit n,
                                     input logic [1:0] opv, input logic [3:0] nv);
    m_rv = 1'b0;
    if (c) begin
      model_reset();
    end else if (m_phase == M_EXEC) begin
      m_left--;
      if (m_left == 0) begin
        m_result = calc_y(m_opa, m_opb, m_ss);
        exp_q.push_back(m_result);
        m_rv = 1'b1;
        m_phase = M_DONE;
      end
    end else if (e) begin
      if (m_phase == M_B) begin
        if (m_ss == 2'd3 && m_opb == 4'd0) m_phase = M_ERR;
        else begin m_phase = M_EXEC; m_left = lat_of(m_ss); end
      end
    end else if (o) begin
      case (m_phase)
        M_A, M_OP: begin m_ss = opv; m_phase = M_OP; end
        M_B:       m_ss = opv;
        M_DONE:    begin m_opa = m_result[3:0]; m_ss = opv; m_phase = M_OP; end
        default:   ;
      endcase
    end else if (n) begin
      case (m_phase)
        M_OP, M_B: begin m_opb = nv; m_phase = M_B; end
        default:   begin m_opa = nv; m_phase = M_A; end
      endcase
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic apply(input bit c, input bit e, input bit o, input bit n,
                       input logic [1:0] opv, input logic [3:0] nv);
    clr = c; eq_valid = e; op_valid = o; num_valid = n; op = opv; num = nv;
    y = calc_y(m_opa, m_opb, m_ss);
    @(posedge clk);
    #1;
    clr = 1'b0; eq_valid = 1'b0; op_valid = 1'b0; num_valid = 1'b0;
    model_step(c, e, o, n, opv, nv);
  endtask

  task automatic key_num(input logic [3:0] v); apply(0, 0, 0, 1, 2'd0, v); endtask
  task automatic key_op(input logic [1:0] v);  apply(0, 0, 1, 0, v, 4'd0); endtask
  task automatic idle();                       apply(0, 0, 0, 0, 2'd0, 4'd0); endtask

  // Presses eq (optionally with extra strobes) and waits for result_valid.
  task automatic eq_and_wait(input bit o, input bit n, input logic [1:0] opv, input logic [3:0] nv,
                             output int edges, output int busy_n, output int mux_n);
    edges = 1; busy_n = 0; mux_n = 0;
    apply(0, 1, o, n, opv, nv);
    forever begin
      if (busy) busy_n++;
      if (mux_en) mux_n++;
      if (result_valid || edges >= 40) break;
      idle();
      edges++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL eq_wait_timeout: result_valid=%0b after %0d cycles, required 1", result_valid, edges);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({opa, opb, ss, result, result_valid, busy, err, mux_en} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {opa, opb, ss, result, result_valid, busy, err, mux_en});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_add();
    int edges, busy_n, mux_n;
    key_num(4'd5); key_op(OP_ADD); key_num(4'd3);
    checks++;
    if ({opa, opb, ss} !== {4'd5, 4'd3, 2'd0}) begin
      errors++; $display("FAIL add_operands: got %h required %h", {opa, opb, ss}, {4'd5, 4'd3, 2'd0});
    end
    eq_and_wait(0, 0, 2'd0, 4'd0, edges, busy_n, mux_n);
    checks++;
    if (edges !== 2) begin errors++; $display("FAIL add_latency: got %0d required 2", edges); end
    checks++;
    if (mux_n !== 1) begin errors++; $display("FAIL add_mux_en_cycles: got %0d required 1", mux_n); end
    checks++;
    if (result !== 8'h08) begin errors++; $display("FAIL add_result: got %h required 08", result); end
    idle();
    checks++;
    if ({result_valid, result} !== {1'b0, 8'h08}) begin
      errors++; $display("FAIL add_hold: got rv=%0b result=%h required rv=0 result=08", result_valid, result);
    end
  endtask

  task automatic test_div();
    int edges, busy_n, mux_n;
    key_num(4'd12); key_op(OP_DIV); key_num(4'd4);
    eq_and_wait(0, 0, 2'd0, 4'd0, edges, busy_n, mux_n);
    checks++;
    if (busy_n !== DIV_LAT) begin errors++; $display("FAIL div_busy_cycles: got %0d required %0d", busy_n, DIV_LAT); end
    checks++;
    if (edges !== 5) begin errors++; $display("FAIL div_latency: got %0d required 5", edges); end
    checks++;
    if (result !== 8'h03) begin errors++; $display("FAIL div_result: got %h required 03", result); end
  endtask

  task automatic test_div_zero();
    int rv_seen;
    rv_seen = 0;
    key_num(4'd9); key_op(OP_DIV); key_num(4'd0);
    apply(0, 1, 0, 0, 2'd0, 4'd0);
    if (result_valid) rv_seen++;
    checks++;
    if ({err, busy} !== 2'b10) begin errors++; $display("FAIL div0_err: got err=%0b busy=%0b required err=1 busy=0", err, busy); end
    checks++;
    if (dbg_state !== ST_ERR) begin errors++; $display("FAIL div0_state: got %0d required %0d", dbg_state, ST_ERR); end
    repeat (3) begin
      idle();
      if (result_valid) rv_seen++;
    end
    checks++;
    if (rv_seen !== 0) begin errors++; $display("FAIL div0_no_result: got %0d pulses required 0", rv_seen); end
    key_num(4'd2);
    checks++;
    if ({err, opa} !== {1'b0, 4'd2}) begin errors++; $display("FAIL div0_recover: got err=%0b opa=%0d required err=0 opa=2", err, opa); end
  endtask

  task automatic test_chain();
    int edges, busy_n, mux_n;
    key_num(4'd13); key_op(OP_MUL); key_num(4'd2);
    eq_and_wait(0, 0, 2'd0, 4'd0, edges, busy_n, mux_n);
    checks++;
    if (result !== 8'h1A) begin errors++; $display("FAIL chain_first: got %h required 1a", result); end
    key_op(OP_MUL);
    checks++;
    if ({opa, ss} !== {4'hA, 2'd2}) begin errors++; $display("FAIL chain_opa: got opa=%h ss=%0d required opa=a ss=2", opa, ss); end
    key_num(4'd3); key_num(4'd7);
    checks++;
    if (opb !== 4'd7) begin errors++; $display("FAIL chain_overwrite: got %0d required 7", opb); end
    eq_and_wait(0, 0, 2'd0, 4'd0, edges, busy_n, mux_n);
    checks++;
    if (busy_n !== MUL_LAT) begin errors++; $display("FAIL chain_mul_cycles: got %0d required %0d", busy_n, MUL_LAT); end
    checks++;
    if (result !== 8'h46) begin errors++; $display("FAIL chain_result: got %h required 46", result); end
  endtask

  task automatic test_clr_exec();
    int rv_seen;
    rv_seen = 0;
    key_num(4'd12); key_op(OP_DIV); key_num(4'd4);
    apply(0, 1, 0, 0, 2'd0, 4'd0);
    idle();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy: got %0b required 1", busy); end
    apply(1, 0, 0, 0, 2'd0, 4'd0);
    if (result_valid) rv_seen++;
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL clr_state: got %0d required %0d", dbg_state, ST_IDLE); end
    checks++;
    if ({opa, opb, ss, result, busy, mux_en} !== 18'd0) begin
      errors++; $display("FAIL clr_outputs: got %h required 0", {opa, opb, ss, result, busy, mux_en});
    end
    repeat (5) begin
      idle();
      if (result_valid) rv_seen++;
    end
    checks++;
    if (rv_seen !== 0) begin errors++; $display("FAIL clr_no_result: got %0d pulses required 0", rv_seen); end
  endtask

  task automatic test_priority();
    int edges, busy_n, mux_n;
    key_num(4'd4);
    apply(0, 0, 1, 1, OP_MUL, 4'd11);
    checks++;
    if ({opa, ss} !== {4'd4, 2'd2}) begin errors++; $display("FAIL prio_op_over_num: got opa=%0d ss=%0d required opa=4 ss=2", opa, ss); end
    key_op(OP_ADD); key_num(4'd6); key_op(OP_ADD);
    eq_and_wait(1, 1, OP_DIV, 4'd9, edges, busy_n, mux_n);
    checks++;
    if ({ss, opb} !== {2'd0, 4'd6}) begin errors++; $display("FAIL prio_eq_only: got ss=%0d opb=%0d required ss=0 opb=6", ss, opb); end
    checks++;
    if ({edges, 24'd0, result} !== {32'd2, 24'd0, 8'h0A}) begin
      errors++; $display("FAIL prio_result: got edges=%0d result=%h required edges=2 result=0a", edges, result);
    end
  endtask

  task automatic test_async_reset();
    key_num(4'd12); key_op(OP_DIV); key_num(4'd4);
    apply(0, 1, 0, 0, 2'd0, 4'd0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({opa, opb, ss, result, result_valid, busy, err, mux_en} !== 26'd0) begin
      errors++; $display("FAIL async_reset_outputs: got %h required 0", {opa, opb, ss, result, result_valid, busy, err, mux_en});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL async_reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    key_num(4'd5);
    checks++;
    if (opa !== 4'd5) begin errors++; $display("FAIL async_reset_resume: got %0d required 5", opa); end
  endtask

  task automatic test_random();
    bit c, e, o, n;
    logic [7:0] exp_r;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 99) < 4);
      e = ($urandom_range(0, 5) == 0);
      o = ($urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 2) == 0);
      apply(c, e, o, n, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      checks++;
      if ({opa, opb, ss} !== {m_opa, m_opb, m_ss}) begin
        errors++; $display("FAIL rand_operands[%0d]: got %h required %h", i, {opa, opb, ss}, {m_opa, m_opb, m_ss});
      end
      checks++;
      if (result !== m_result) begin errors++; $display("FAIL rand_result[%0d]: got %h required %h", i, result, m_result); end
      checks++;
      if ({busy, mux_en, err, result_valid} !== {m_phase == M_EXEC, m_phase == M_EXEC, m_phase == M_ERR, m_rv}) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got %b required %b", i, {busy, mux_en, err, result_valid},
                 {m_phase == M_EXEC, m_phase == M_EXEC, m_phase == M_ERR, m_rv});
      end
      if (result_valid) begin
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : ~result;
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL rand_scoreboard[%0d]: got %h required %h", i, result, exp_r); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d pending results required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_div();
    test_div_zero();
    test_chain();
    test_clr_exec();
    test_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
